// File: rtl/encoder16x4_seq_if.sv
// Request/response bundle for encoder16x4_seq.
// The producer drives the master side and encoder16x4_seq takes the slave side.
interface encoder16x4_seq_if;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic        ack;
    logic [3:0]  dout;
    logic        valid;
    logic        busy;
    logic [4:0]  remaining;
    logic        done;

    modport master (
        output en, load, din, ack,
        input  dout, valid, busy, remaining, done
    );

    modport slave (
        input  en, load, din, ack,
        output dout, valid, busy, remaining, done
    );
endinterface

// File: rtl/encoder16x4_seq.sv
// Sequential 16-to-4 priority encoder.
// A multi-hot vector is captured and its set bit indices are emitted one per
// acknowledge, lowest index first. A one-cycle done pulse marks the end.
module encoder16x4_seq (
    input  logic                 clk,
    input  logic                 rst,
    encoder16x4_seq_if.slave     bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OUT  = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_pend;
    logic [3:0]  r_dout;
    logic        r_valid;
    logic        r_busy;
    logic [4:0]  r_rem;
    logic        r_done;

    logic [15:0] w_cleared;
    logic        w_load_go;
    logic        w_ack_go;

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Number of set bits, 0..16.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // The pending set with the code currently on dout removed.
    assign w_cleared = r_pend & ~(16'h0001 << r_dout);

    // Qualified load (idle only, non-empty vector) and qualified ack (outputting only).
    assign w_load_go = bus.en && (r_state == IDLE) && bus.load && (bus.din != 16'h0000);
    assign w_ack_go  = bus.en && (r_state == OUT) && bus.ack && r_valid;

    // FSM plus pending set; done is cleared every edge, so a pulse drops even while en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= 16'h0000;
            r_dout  <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_rem   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load_go) begin
                r_state <= OUT;
                r_pend  <= bus.din;
                r_dout  <= lowest_idx(bus.din);
                r_rem   <= popcount16(bus.din);
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_ack_go) begin
                r_pend <= w_cleared;
                if (w_cleared != 16'h0000) begin
                    r_dout <= lowest_idx(w_cleared);
                    r_rem  <= r_rem - 5'd1;
                end else begin
                    // Last code consumed: dout keeps its final value.
                    r_state <= IDLE;
                    r_rem   <= 5'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.remaining = r_rem;
    assign bus.done      = r_done;

endmodule

// File: doc/encoder16x4_seq.md
ENCODER16X4_SEQ -- requirements
Module: encoder16x4_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset; forces all state to reset values immediately.
REQ-004 en  input  1  block enable; when 0, load and ack are ignored and all state holds.
REQ-005 load  input  1  capture request; samples din when the block is idle.
REQ-006 din  input  16  one-hot or multi-hot request vector; bit i requests code i.
REQ-007 ack  input  1  consumer acknowledge of the current dout; acts only while valid=1.
REQ-008 dout  output  4  registered binary index of the lowest-numbered pending bit.
REQ-009 valid  output  1  registered; dout holds a code not yet acknowledged.
REQ-010 busy  output  1  registered; pending set is non-empty (state OUT).
REQ-011 remaining  output  5  registered population count of pending bits, range 0..16.
REQ-012 done  output  1  registered one-cycle pulse after the last code is acknowledged.

Function
REQ-013 The block SHALL hold an internal 16-bit pending register pend and a two-state FSM, IDLE and OUT.
REQ-014 In IDLE, a rising edge with en=1, load=1 and din!=0 SHALL set pend=din, dout=lowest set index of din, remaining=popcount(din), valid=1, busy=1, and enter OUT.
REQ-015 Load latency SHALL be one cycle: the first code and valid are visible in the cycle after the load edge.
REQ-016 In IDLE, load with din=16'h0000 SHALL be ignored: state, outputs and done remain unchanged, and no error is raised.
REQ-017 In OUT, an edge with en=1, ack=1 and valid=1 SHALL clear bit dout of pend and decrement remaining by 1.
REQ-018 If the cleared pend is non-zero, that edge SHALL load dout with the lowest set index of the cleared pend, keeping valid=1 with no bubble cycle.
REQ-019 If the cleared pend is zero, that edge SHALL set valid=0, busy=0, remaining=0 and done=1, and return to IDLE; dout SHALL hold its last value.
REQ-020 done SHALL be 1 for exactly one cycle and 0 otherwise.
REQ-021 load asserted in OUT SHALL be ignored; pend is not modified.
REQ-022 When load and ack are asserted together, only the input relevant to the current state SHALL act: load in IDLE, ack in OUT.
REQ-023 ack in IDLE SHALL have no effect.
REQ-024 With en=0, all registers SHALL hold, including during OUT; an in-progress done pulse SHALL still return to 0 on the next edge.
REQ-025 Codes SHALL be emitted in strictly ascending index order; din=16'hFFFF SHALL produce codes 0..15 with remaining 16..1.
REQ-026 remaining SHALL always equal popcount(pend) and be 0 exactly when busy=0.

Reset
REQ-027 On rst=1, the block SHALL go to IDLE with pend=0, dout=0, valid=0, busy=0, remaining=0 and done=0, asynchronously and regardless of clk.
REQ-028 Reset asserted mid-operation SHALL abandon all pending codes and raise no done pulse.
REQ-029 After rst deasserts, the first load SHALL be accepted on the first qualifying clock edge.

Verification
REQ-030 Reset: assert rst between clock edges -> all outputs read 0 before the next edge; after release, with no load, outputs stay 0.
REQ-031 Zero load: en=1, load=1, din=16'h0000 -> busy=0, valid=0, done=0 for all following cycles.
REQ-032 Sparse vector: load din=16'h8421, ack every cycle -> dout sequence 0,5,10,15 with remaining 4,3,2,1; done=1 one cycle after the 4th ack, then busy=0 and dout=15.
REQ-033 Full vector: load din=16'hFFFF, ack held high -> 16 consecutive valid cycles with dout 0..15 and remaining 16..1; a single done pulse follows.
REQ-034 Ignored inputs: during OUT of din=16'h0003, pulse load with din=16'hFF00 and pulse ack with en=0 -> dout stays 0 and remaining stays 2; later acks yield 1, then done.
REQ-035 Reset mid-operation: load din=16'h00F0, ack once (dout=5), then assert rst -> all outputs 0 and no done pulse; a following load of 16'h0001 gives dout=0 and remaining=1.
